memory_module: RTL and testbench

Byte-wide 256-entry data memory for the processor datapath, with direct and one-level indirect addressing. The control unit issues single-cycle `start` commands carrying an operation code, an address and write data. The block performs reads, writes or read-and-write swaps, and presents read results on a registered output. It sits between the control unit/ALU and the register file as the processor's only RAM.

---
 rtl/memory_module_if.sv | 27 ++
 rtl/memory_module.sv | 109 ++++++++++
 tb/tb_memory_module.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/memory_module_if.sv
// Command/response bundle between the control unit (master) and the data memory (slave).
interface memory_module_if;
  logic       isIndirect;
  logic       start;
  logic [1:0] cntrl;
  logic [7:0] addr;
  logic [7:0] dataIn;
  logic [7:0] dataOut;

  modport master (
    output isIndirect,
    output start,
    output cntrl,
    output addr,
    output dataIn,
    input  dataOut
  );

  modport slave (
    input  isIndirect,
    input  start,
    input  cntrl,
    input  addr,
    input  dataIn,
    output dataOut
  );
endinterface

// File: rtl/memory_module.sv
// 256x8 register-based data memory with direct and one-level indirect addressing.
// Direct commands execute on the start edge; indirect ones fetch a pointer first.
module memory_module (
  input  logic                  clk,
  input  logic                  clrRAM,
  memory_module_if.slave        bus
);

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_SWAP  = 2'b11;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    INDIR = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                exec_en;
  logic [1:0]          exec_op;
  logic [ADDR_W-1:0]   exec_ea;
  logic [DATA_W-1:0]   exec_data;

  // Command source: live inputs in IDLE, the latched indirect command in INDIR.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    op_d      = op_q;
    data_d    = data_q;
    exec_en   = 1'b0;
    exec_op   = bus.cntrl;
    exec_ea   = bus.addr;
    exec_data = bus.dataIn;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.isIndirect) begin
            ptr_d   = mem_q[bus.addr];
            op_d    = bus.cntrl;
            data_d  = bus.dataIn;
            state_d = INDIR;
          end else begin
            exec_en = 1'b1;
          end
        end
      end
      INDIR: begin
        exec_en   = 1'b1;
        exec_op   = op_q;
        exec_ea   = ptr_q;
        exec_data = data_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Execution: SWAP reads the old word before the write lands on the same edge.
  always_comb begin
    mem_d  = mem_q;
    dout_d = dout_q;
    if (exec_en) begin
      case (exec_op)
        OP_NOP: ;
        OP_READ: dout_d = mem_q[exec_ea];
        OP_WRITE: mem_d[exec_ea] = exec_data;
        OP_SWAP: begin
          dout_d         = mem_q[exec_ea];
          mem_d[exec_ea] = exec_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrRAM) begin
    if (!clrRAM) begin
      state_q <= IDLE;
      mem_q   <= '{default: '0};
      dout_q  <= '0;
      ptr_q   <= '0;
      op_q    <= OP_NOP;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      dout_q  <= dout_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      data_q  <= data_d;
    end
  end

  assign bus.dataOut = dout_q;

endmodule

// File: tb/tb_memory_module.sv
// Bench for memory_module: directed vector table, reset sequences, random and counter stimulus
// checked against an array-based reference model.
`timescale 1ns/1ps
module tb_memory_module;

  logic clk;
  logic clrRAM;
  memory_module_if bus ();

  memory_module dut (
    .clk    (clk),
    .clrRAM (clrRAM),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  // Reference model state
  logic [7:0] m_mem [256];
  logic [7:0] m_dout;
  bit         m_busy;
  logic [1:0] m_op;
  logic [7:0] m_data;
  logic [7:0] m_ptr;

  typedef struct {
    logic       ind;
    logic       st;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [22];

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    m_dout = 8'h00;
    m_busy = 1'b0;
    m_op   = 2'b00;
    m_data = 8'h00;
    m_ptr  = 8'h00;
  endtask

  task automatic model_exec(input logic [1:0] op, input logic [7:0] ea, input logic [7:0] d);
    logic [7:0] old;
    old = m_mem[ea];
    if (op == 2'd1 || op == 2'd3) m_dout = old;
    if (op == 2'd2 || op == 2'd3) m_mem[ea] = d;
  endtask

  task automatic model_edge();
    if (m_busy) begin
      model_exec(m_op, m_ptr, m_data);
      m_busy = 1'b0;
    end else if (bus.start) begin
      if (bus.isIndirect) begin
        m_ptr  = m_mem[bus.addr];
        m_op   = bus.cntrl;
        m_data = bus.dataIn;
        m_busy = 1'b1;
      end else begin
        model_exec(bus.cntrl, bus.addr, bus.dataIn);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_mem(input string name);
    int bad;
    int first;
    bad   = 0;
    first = -1;
    for (int i = 0; i < 256; i++) begin
      if (dut.mem_q[i[7:0]] !== m_mem[i[7:0]]) begin
        if (first < 0) first = i;
        bad++;
      end
    end
    nvec++;
    if (bad != 0) begin
      nmis++;
      $display("FAIL %s: %0d words differ, first mem[%0d] got %h want %h at %0t",
               name, bad, first, dut.mem_q[first[7:0]], m_mem[first[7:0]], $time);
    end
  endtask

  task automatic check_model(input string name);
    nvec++;
    if ($isunknown(bus.dataOut) || bus.dataOut !== m_dout) begin
      nmis++;
      $display("FAIL %s dataOut: got %h want %h at %0t", name, bus.dataOut, m_dout, $time);
    end
    check_mem(name);
  endtask

  task automatic cycle(input logic ind, input logic st, input logic [1:0] op,
                       input logic [7:0] a, input logic [7:0] d, input string name);
    @(negedge clk);
    bus.isIndirect = ind;
    bus.start      = st;
    bus.cntrl      = op;
    bus.addr       = a;
    bus.dataIn     = d;
    @(posedge clk);
    model_edge();
    #1;
    check_model(name);
  endtask

  // Called just after a posedge; the pulse sits entirely between clock edges.
  task automatic pulse_reset(input string name);
    #2;
    clrRAM = 1'b0;
    model_reset();
    #1;
    check_val({name, "_dout"}, bus.dataOut, 8'h00);
    check_mem({name, "_mem"});
    #0.5;
    clrRAM = 1'b1;
  endtask

  task automatic load_tbl();
    tbl[0]  = '{1'b0, 1'b1, 2'd2, 8'h20, 8'h3C, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 2'd1, 8'h20, 8'h00, 8'h3C};
    tbl[2]  = '{1'b0, 1'b1, 2'd2, 8'h05, 8'h80, 8'h3C};
    tbl[3]  = '{1'b0, 1'b1, 2'd2, 8'h80, 8'h7E, 8'h3C};
    tbl[4]  = '{1'b1, 1'b1, 2'd1, 8'h05, 8'h00, 8'h3C};
    tbl[5]  = '{1'b0, 1'b1, 2'd2, 8'h80, 8'hFF, 8'h7E};
    tbl[6]  = '{1'b0, 1'b1, 2'd1, 8'h80, 8'h00, 8'h7E};
    tbl[7]  = '{1'b1, 1'b1, 2'd2, 8'h05, 8'h11, 8'h7E};
    tbl[8]  = '{1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h7E};
    tbl[9]  = '{1'b0, 1'b1, 2'd3, 8'h80, 8'h22, 8'h11};
    tbl[10] = '{1'b0, 1'b1, 2'd1, 8'h80, 8'h00, 8'h22};
    tbl[11] = '{1'b1, 1'b1, 2'd3, 8'h05, 8'hAB, 8'h22};
    tbl[12] = '{1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h22};
    tbl[13] = '{1'b0, 1'b1, 2'd1, 8'h80, 8'h00, 8'hAB};
    tbl[14] = '{1'b0, 1'b1, 2'd2, 8'h05, 8'h05, 8'hAB};
    tbl[15] = '{1'b1, 1'b1, 2'd1, 8'h05, 8'h00, 8'hAB};
    tbl[16] = '{1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h05};
    tbl[17] = '{1'b1, 1'b1, 2'd0, 8'h05, 8'h00, 8'h05};
    tbl[18] = '{1'b0, 1'b1, 2'd1, 8'h20, 8'h00, 8'h05};
    tbl[19] = '{1'b0, 1'b1, 2'd1, 8'h20, 8'h00, 8'h3C};
    tbl[20] = '{1'b0, 1'b1, 2'd2, 8'hFF, 8'h5A, 8'h3C};
    tbl[21] = '{1'b0, 1'b1, 2'd1, 8'hFF, 8'h00, 8'h5A};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] cnt;
    clrRAM         = 1'b0;
    bus.isIndirect = 1'b0;
    bus.start      = 1'b0;
    bus.cntrl      = 2'b00;
    bus.addr       = 8'h00;
    bus.dataIn     = 8'h00;
    model_reset();

    // Reset state, with clock edges passing while held in reset
    #3;
    check_val("reset_dout", bus.dataOut, 8'h00);
    check_mem("reset_mem");
    bus.start = 1'b1;
    bus.cntrl = 2'd2;
    bus.dataIn = 8'hEE;
    @(posedge clk);
    #1;
    check_mem("reset_hold_mem");
    @(negedge clk);
    bus.start = 1'b0;
    clrRAM = 1'b1;

    // Reset clear
    cycle(1'b0, 1'b1, 2'd2, 8'h10, 8'hAA, "rc_wr10");
    cycle(1'b0, 1'b1, 2'd2, 8'hFF, 8'h55, "rc_wrff");
    cycle(1'b0, 1'b1, 2'd1, 8'hFF, 8'h00, "rc_rdff_pre");
    check_val("rc_pre_value", bus.dataOut, 8'h55);
    pulse_reset("rc_pulse");
    cycle(1'b0, 1'b1, 2'd1, 8'h10, 8'h00, "rc_rd10");
    check_val("rc_rd10_zero", bus.dataOut, 8'h00);
    cycle(1'b0, 1'b1, 2'd1, 8'hFF, 8'h00, "rc_rdff");
    check_val("rc_rdff_zero", bus.dataOut, 8'h00);

    // Directed vector table
    load_tbl();
    for (int i = 0; i < 22; i++) begin
      cycle(tbl[i].ind, tbl[i].st, tbl[i].op, tbl[i].a, tbl[i].d, $sformatf("tbl%0d", i));
      check_val($sformatf("tbl%0d_exp", i), bus.dataOut, tbl[i].exp);
    end

    // Reset while an indirect write is pending
    cycle(1'b0, 1'b1, 2'd2, 8'h05, 8'h80, "ri_ptr");
    cycle(1'b1, 1'b1, 2'd2, 8'h05, 8'h99, "ri_launch");
    pulse_reset("ri_pulse");
    cycle(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, "ri_idle");
    check_val("ri_mem80", dut.mem_q[8'h80], 8'h00);
    cycle(1'b0, 1'b1, 2'd2, 8'h30, 8'h44, "ri_wr30");
    cycle(1'b0, 1'b1, 2'd1, 8'h30, 8'h00, "ri_rd30");
    check_val("ri_direct_after", bus.dataOut, 8'h44);

    // Randomized commands, concentrated on a few addresses to create pointer/data overlap
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] ra;
      ra = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      cycle(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)),
            ra, 8'($urandom_range(0, 255)), "rand");
      if ($urandom_range(0, 199) == 0) pulse_reset("rand_rst");
    end

    // Counter-driven encodings; odd stride walks every field combination over time
    cnt = 20'($urandom_range(0, 1048575));
    for (int i = 0; i < 3000; i++) begin
      cycle(cnt[19], cnt[18], cnt[17:16], cnt[15:8], cnt[7:0], "count");
      cnt = cnt + 20'h2F5C3;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
